// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit RISC core: datapath width, reset PC and ALU opcodes.
// The sequencer and the execution unit both import this package.
package cpu_pkg;

  localparam int          DW       = 16;
  localparam logic [15:0] PC_RESET = 16'h0000;

  localparam logic [3:0] ALU_PASS_S = 4'b0000;
  localparam logic [3:0] ALU_PASS_R = 4'b0001;
  localparam logic [3:0] ALU_INC    = 4'b0010;
  localparam logic [3:0] ALU_DEC    = 4'b0011;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_SUB    = 4'b0101;
  localparam logic [3:0] ALU_SHR    = 4'b0110;
  localparam logic [3:0] ALU_SHL    = 4'b0111;
  localparam logic [3:0] ALU_AND    = 4'b1000;
  localparam logic [3:0] ALU_OR     = 4'b1001;
  localparam logic [3:0] ALU_XOR    = 4'b1010;
  localparam logic [3:0] ALU_NOT    = 4'b1011;

endpackage

// File: rtl/reg_file8x16.sv
// Register file: two asynchronous read ports, one synchronous write port, synchronous clear.
// Reads during a write return the pre-edge contents.
module reg_file8x16 #(
  parameter int DW = 16,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [RA-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [RA-1:0] ra_r,
  input  logic [RA-1:0] ra_s,
  output logic [DW-1:0] rd_r,
  output logic [DW-1:0] rd_s
);

  localparam int NREG = 1 << RA;

  logic [NREG-1:0][DW-1:0] regs;

  always_ff @(posedge clk) begin
    if (reset)   regs     <= '0;
    else if (we) regs[wa] <= wd;
  end

  assign rd_r = regs[ra_r];
  assign rd_s = regs[ra_s];

endmodule

// File: rtl/cpu_eu.sv
// Execution unit: PC, IR, register file and combinational ALU.
// Flags are presented combinationally; the sequencer decides when to capture them.
module cpu_eu #(
  parameter int          DW       = cpu_pkg::DW,
  parameter int          RA       = 3,
  parameter logic [DW-1:0] PC_RESET = cpu_pkg::PC_RESET
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RA-1:0] W_Adr,
  input  logic [RA-1:0] R_Adr,
  input  logic [RA-1:0] S_Adr,
  input  logic          adr_sel,
  input  logic          s_sel,
  input  logic          pc_ld,
  input  logic          pc_inc,
  input  logic          pc_sel,
  input  logic          ir_ld,
  input  logic          rw_en,
  input  logic [3:0]    alu_op,
  input  logic [DW-1:0] D_in,
  output logic [DW-1:0] Address,
  output logic [DW-1:0] D_out,
  output logic [DW-1:0] IR,
  output logic          N,
  output logic          Z,
  output logic          C
);

  import cpu_pkg::*;

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] pc_q, ir_q;
  logic [DW-1:0] reg_r, reg_s;
  logic [DW-1:0] alu_res, wd;
  logic [DW:0]   alu_x;
  logic [DW-1:0] pc_tgt;

  assign wd = s_sel ? D_in : alu_res;

  reg_file8x16 #(.DW(DW), .RA(RA)) u_rf (
    .clk  (clk),
    .reset(reset),
    .we   (rw_en),
    .wa   (W_Adr),
    .wd   (wd),
    .ra_r (R_Adr),
    .ra_s (S_Adr),
    .rd_r (reg_r),
    .rd_s (reg_s)
  );

  // 17-bit result: bit DW carries C for every op
  always_comb begin
    alu_x = '0;
    case (alu_op)
      ALU_PASS_S: alu_x = {1'b0, reg_s};
      ALU_PASS_R: alu_x = {1'b0, reg_r};
      ALU_INC:    alu_x = {1'b0, reg_s} + {1'b0, ONE};
      ALU_DEC:    alu_x = {(reg_s == '0), reg_s - ONE};
      ALU_ADD:    alu_x = {1'b0, reg_r} + {1'b0, reg_s};
      ALU_SUB:    alu_x = {1'b0, reg_r} - {1'b0, reg_s};
      ALU_SHR:    alu_x = {reg_s[0], 1'b0, reg_s[DW-1:1]};
      ALU_SHL:    alu_x = {reg_s[DW-1], reg_s[DW-2:0], 1'b0};
      ALU_AND:    alu_x = {1'b0, reg_r & reg_s};
      ALU_OR:     alu_x = {1'b0, reg_r | reg_s};
      ALU_XOR:    alu_x = {1'b0, reg_r ^ reg_s};
      ALU_NOT:    alu_x = {1'b0, ~reg_s};
      default:    alu_x = '0;
    endcase
  end

  assign alu_res = alu_x[DW-1:0];
  assign C       = alu_x[DW];
  assign N       = alu_res[DW-1];
  assign Z       = (alu_res == '0);

  // Relative target uses the already-incremented PC
  assign pc_tgt = pc_sel ? reg_r : pc_q + {{(DW-8){ir_q[7]}}, ir_q[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_RESET;
      ir_q <= '0;
    end else begin
      if (pc_ld)       pc_q <= pc_tgt;
      else if (pc_inc) pc_q <= pc_q + ONE;
      if (ir_ld)       ir_q <= D_in;
    end
  end

  assign Address = adr_sel ? reg_r : pc_q;
  assign D_out   = reg_s;
  assign IR      = ir_q;

endmodule
